// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage constants
// Purpose: default widths/depth for the fetch stage, NOP encoding and reset vector.
// Ports: none (package).
package fetch_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;

    localparam logic [INSTR_W-1:0] NOP          = 16'h0000;
    localparam logic [ADDR_W-1:0]  RESET_VECTOR = 12'h000;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO holding {instr, pc} entries
// Purpose: small power-of-two FIFO with flush; head is read combinationally.
// Ports:
//   CLOCK_50  in   clock
//   reset     in   synchronous, active-high
//   flush     in   drop all entries (wins over push/pop)
//   push      in   write push_data at tail
//   push_data in   entry to write
//   pop       in   retire head entry (ignored when empty)
//   count     out  number of valid entries, 0..DEPTH
//   head_data out  entry at head (meaningful only when count != 0)
module fetch_fifo #(
    parameter int WIDTH = fetch_pkg::INSTR_W + fetch_pkg::ADDR_W,
    parameter int DEPTH = fetch_pkg::DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && (count != '0);
    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge CLOCK_50) begin
        if (do_push && !reset && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch stage with PC-tagged prefetch queue
// Purpose: owns the fetch PC, reads the 1-cycle-latency ROM, queues words with
//          their PCs for the decoder, and flushes on branch/jump redirects.
// Ports:
//   CLOCK_50        in   clock
//   reset           in   synchronous, active-high
//   imem_addr       out  ROM address (the fetch PC)
//   imem_rd         out  imem_addr is a real fetch this cycle
//   imem_q          in   ROM data, valid the cycle after imem_rd
//   redirect_valid  in   restart fetch at redirect_pc
//   redirect_pc     in   restart address
//   out_valid       out  head entry valid
//   out_instr       out  head instruction (0 when empty)
//   out_pc          out  head PC (0 when empty)
//   out_ready       in   decoder takes the head this cycle
module instr_fetch_queue #(
    parameter int ADDR_W  = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    parameter int DEPTH   = fetch_pkg::DEPTH
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_q,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready
);

    import fetch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = INSTR_W + ADDR_W;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] fpc_tag;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  head_data;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              push;
    logic              pop;

    // Reserve a slot for the read still in flight; a same-cycle pop is not
    // credited, so the queue can never be overrun.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue     = !reset && !redirect_valid && (occupancy < DEPTH_LIM);

    assign imem_addr = fpc;
    assign imem_rd   = issue;

    // A redirect kills the returning word and overrides the decoder's pop.
    assign push = inflight && !redirect_valid && !reset;
    assign pop  = out_valid && out_ready && !redirect_valid;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            fpc      <= ADDR_W'(RESET_VECTOR);
            fpc_tag  <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            fpc      <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fpc     <= fpc + ADDR_W'(1);
                fpc_tag <= fpc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({imem_q, fpc_tag}),
        .pop       (pop),
        .count     (count),
        .head_data (head_data)
    );

    assign out_valid = (count != '0);
    assign out_instr = out_valid ? head_data[ENT_W-1:ADDR_W] : INSTR_W'(NOP);
    assign out_pc    = out_valid ? head_data[ADDR_W-1:0]     : '0;

endmodule
